fec_block_ctrl: RTL

- Sequences the combinational `fec` encoder (48-bit `data_in` to 96-bit `fec_out`) for a byte-stream transmitter.
- Packs incoming bytes MSB-first into a 48-bit block, optionally bit-reverses it, and presents it to the encoder.
- Captures the 96-bit codeword and serializes it MSB-first over a valid/ready bit interface.
- Sits between the packet byte source and the modulator's bit input. The `fec` instance is external, wired via `fec_data` and `fec_code`.

---
 rtl/fec_block_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/fec_block_ctrl.sv
// fec_block_ctrl: packs bytes into 48-bit blocks for the external fec encoder and serializes the 96-bit codeword
module fec_block_ctrl #(
  parameter bit         BIT_REVERSE = 1'b0,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [47:0] fec_data,
  input  logic [95:0] fec_code,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        block_done,
  output logic        busy
);
  localparam logic [1:0] LOAD = 2'd0, PAD = 2'd1, ENCODE = 2'd2, SHIFT = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [47:0] pack_q, pack_d, fec_data_q, fec_data_d, pack_rev;
  logic [95:0] shreg_q, shreg_d;
  logic [2:0]  bytecnt_q, bytecnt_d;
  logic [6:0]  bitcnt_q, bitcnt_d;
  logic        acc, wr, xfer, last_bit;
  assign in_ready   = (state_q == LOAD) & ~reset;
  assign acc        = in_valid & in_ready;
  assign xfer       = (state_q == SHIFT) & bit_ready;
  assign last_bit   = bitcnt_q == 7'd95;
  assign block_done = xfer & last_bit & ~reset;
  assign bit_valid  = state_q == SHIFT;
  assign bit_out    = shreg_q[95];
  assign busy       = state_q != LOAD;
  assign fec_data   = fec_data_q;
  always_comb begin
    pack_rev = '0;
    for (int i = 0; i < 48; i++) pack_rev[i] = pack_d[47-i];
  end
  always_comb begin
    wr         = ((state_q == LOAD) & acc) | (state_q == PAD);
    pack_d     = wr ? {pack_q[39:0], (state_q == PAD) ? PAD_BYTE : in_byte} : pack_q;
    fec_data_d = wr ? (BIT_REVERSE ? pack_rev : pack_d) : fec_data_q;
    bytecnt_d  = (state_q == ENCODE) ? 3'd0 : wr ? bytecnt_q + 3'd1 : bytecnt_q;
    bitcnt_d   = (state_q == ENCODE) ? 7'd0 : xfer ? bitcnt_q + 7'd1 : bitcnt_q;
    shreg_d    = (state_q == ENCODE) ? fec_code : xfer ? {shreg_q[94:0], 1'b0} : shreg_q;
    state_d    = state_q;
    case (state_q)
      LOAD:    state_d = !acc ? LOAD : (bytecnt_q == 3'd5) ? ENCODE : in_last ? PAD : LOAD;
      PAD:     state_d = (bytecnt_q == 3'd5) ? ENCODE : PAD;
      ENCODE:  state_d = SHIFT;
      default: state_d = (xfer & last_bit) ? LOAD : SHIFT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      pack_q     <= '0;
      fec_data_q <= '0;
      shreg_q    <= '0;
      bytecnt_q  <= '0;
      bitcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      fec_data_q <= fec_data_d;
      shreg_q    <= shreg_d;
      bytecnt_q  <= bytecnt_d;
      bitcnt_q   <= bitcnt_d;
    end
  end
endmodule
